// File: rtl/iob_cache_ram_arbiter.sv
// Clear sequencer and round-robin two-way arbiter in front of a single-port
// byte-write cache RAM with a one-cycle registered read.
module iob_cache_ram_arbiter #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 10,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  clear_i,
   output logic                  busy_o,
   input  logic                  r0_valid_i,
   input  logic [ADDR_W-1:0]     r0_addr_i,
   input  logic [DATA_W/8-1:0]   r0_wstrb_i,
   input  logic [DATA_W-1:0]     r0_wdata_i,
   output logic                  r0_ready_o,
   output logic                  r0_rvalid_o,
   output logic [DATA_W-1:0]     r0_rdata_o,
   input  logic                  r1_valid_i,
   input  logic [ADDR_W-1:0]     r1_addr_i,
   input  logic [DATA_W/8-1:0]   r1_wstrb_i,
   input  logic [DATA_W-1:0]     r1_wdata_i,
   output logic                  r1_ready_o,
   output logic                  r1_rvalid_o,
   output logic [DATA_W-1:0]     r1_rdata_o,
   output logic                  ram_en_o,
   output logic [DATA_W/8-1:0]   ram_we_o,
   output logic [ADDR_W-1:0]     ram_addr_o,
   output logic [DATA_W-1:0]     ram_d_o,
   input  logic [DATA_W-1:0]     ram_d_i
);

   typedef enum logic {CLEAR, SERVE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                last_grant_q, last_grant_d;
   logic                rvalid0_q, rvalid0_d;
   logic                rvalid1_q, rvalid1_d;
   logic                grant;

   // State, sweep counter, fairness pointer and read-return pipeline
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q      <= CLEAR;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
      end
   end

   // Sweep the RAM while clearing, otherwise grant one requester per cycle
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      grant        = 1'b0;
      ram_en_o     = 1'b0;
      ram_we_o     = '0;
      ram_addr_o   = '0;
      ram_d_o      = '0;
      r0_ready_o   = 1'b0;
      r1_ready_o   = 1'b0;
      case (state_q)
         CLEAR: begin
            ram_en_o   = 1'b1;
            ram_we_o   = '1;
            ram_addr_o = cnt_q;
            ram_d_o    = CLEAR_VAL;
            cnt_d      = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (cnt_q == '1) begin
               state_d = SERVE;
               cnt_d   = '0;
            end
         end
         SERVE: begin
            if (clear_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (r0_valid_i || r1_valid_i) begin
               grant        = (r0_valid_i && r1_valid_i) ? ~last_grant_q : r1_valid_i;
               last_grant_d = grant;
               ram_en_o     = 1'b1;
               if (grant) begin
                  r1_ready_o = 1'b1;
                  ram_addr_o = r1_addr_i;
                  ram_we_o   = r1_wstrb_i;
                  ram_d_o    = r1_wdata_i;
                  rvalid1_d  = ~|r1_wstrb_i;
               end else begin
                  r0_ready_o = 1'b1;
                  ram_addr_o = r0_addr_i;
                  ram_we_o   = r0_wstrb_i;
                  ram_d_o    = r0_wdata_i;
                  rvalid0_d  = ~|r0_wstrb_i;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   assign busy_o      = (state_q == CLEAR);
   assign r0_rvalid_o = rvalid0_q;
   assign r1_rvalid_o = rvalid1_q;
   assign r0_rdata_o  = ram_d_i;
   assign r1_rdata_o  = ram_d_i;

endmodule

// File: doc/iob_cache_ram_arbiter.md
Name: iob_cache_ram_arbiter

Overview:
Sequencer and two-way arbiter in front of one byte-write single-port cache RAM (ADDR_W x DATA_W, one write enable per byte, registered read with 1-cycle latency). After reset, and on clear_i, it sweeps every RAM word to CLEAR_VAL. It then shares the RAM between two requesters (0: cache front-end, 1: back-end/replacement) with round-robin arbitration and a valid/ready handshake. It sits between cache control logic and the byte-width RAM array.

Parameters:
DATA_W, 32, RAM word width; multiple of 8
ADDR_W, 10, RAM address width; depth = 2**ADDR_W
CLEAR_VAL, 0, DATA_W-bit value written to every word during a clear sweep

Ports:
clk_i  input  1  clock
arst_i  input  1  asynchronous reset, active-high
clear_i  input  1  pulse: start a clear sweep
busy_o  output  1  high while a clear sweep is in progress
r0_valid_i  input  1  requester 0 request valid
r0_addr_i  input  ADDR_W  requester 0 word address
r0_wstrb_i  input  DATA_W/8  requester 0 byte strobes; all-zero = read
r0_wdata_i  input  DATA_W  requester 0 write data
r0_ready_o  output  1  requester 0 request accepted this cycle
r0_rvalid_o  output  1  requester 0 read data valid
r0_rdata_o  output  DATA_W  requester 0 read data
r1_valid_i, r1_addr_i, r1_wstrb_i, r1_wdata_i, r1_ready_o, r1_rvalid_o, r1_rdata_o: same as requester 0
ram_en_o  output  1  RAM enable
ram_we_o  output  DATA_W/8  RAM byte write enables
ram_addr_o  output  ADDR_W  RAM address
ram_d_o  output  DATA_W  RAM write data
ram_d_i  input  DATA_W  RAM read data (valid 1 cycle after enabled read)

Behaviour:
- Single clock clk_i; arst_i asynchronous, active-high. On reset: FSM=CLEAR, sweep counter=0, last_grant=1 (requester 0 wins first tie), rvalid pipeline cleared, busy_o=1, all ready/rvalid=0.
- FSM states: CLEAR, SERVE.
- CLEAR: each cycle ram_en_o=1, ram_we_o=all ones, ram_addr_o=counter, ram_d_o=CLEAR_VAL; counter increments. On the cycle counter = 2**ADDR_W-1 is written -> SERVE, counter returns to 0. Sweep takes exactly 2**ADDR_W cycles. ready outputs 0 throughout. clear_i while in CLEAR is ignored (no restart).
- SERVE: busy_o=0. Grant computed combinationally: only one valid -> that one; both valid -> requester != last_grant. Granted requester's ready=1 in the same cycle (ready depends on valid); other ready=0. Neither valid -> ram_en_o=0, ram_we_o=0.
- Accepted request drives ram_en_o=1, ram_addr_o=addr, ram_d_o=wdata, ram_we_o=wstrb the same cycle. last_grant updates only on acceptance.
- Read (wstrb==0): rX_rvalid_o=1 exactly one cycle after acceptance, rX_rdata_o=ram_d_i in that cycle. Back-to-back reads (including alternating requesters) sustain one per cycle. Write: no rvalid; write completes at acceptance.
- rdata outputs are ram_d_i pass-through; meaningful only when the matching rvalid is high.
- clear_i in SERVE: takes priority over requests that cycle (no ready asserted); next cycle FSM=CLEAR, counter=0. A read accepted the cycle before clear_i still gets its rvalid.
- Read-after-write to the same address by either requester in consecutive cycles returns the new data (RAM ordering; no bypass needed).
- Reset mid-sweep or mid-read: sweep restarts from 0; pending rvalid dropped.
- Requesters hold valid/addr/wstrb/wdata stable until ready; arbiter does not check.

Test Plan:
- Reset, ADDR_W=4: busy_o=1 for exactly 16 cycles, ram_we_o=all ones, addresses 0..15 with CLEAR_VAL; then busy_o=0; reads of addr 0..15 return CLEAR_VAL.
- r0 writes 0xDEADBEEF to addr 3 with wstrb=4'b1111, then wstrb=4'b0010 data 0x0000AA00 -> r1 read addr 3: r1_rvalid_o one cycle after ready, rdata=0xDEADAAEF.
- Both valid continuously for 6 cycles (reads, distinct addrs) -> grants alternate 0,1,0,1,0,1; each rvalid one cycle after own ready, never both rvalid high together.
- Only r1 valid for 3 cycles -> r1 granted all 3 cycles (no forced idle); subsequent tie goes to r0.
- r0 read accepted at cycle N, clear_i at N+1 -> r0_rvalid_o at N+1 with pre-clear data; busy_o from N+2 for 2**ADDR_W cycles; no ready during sweep.
- arst_i asserted mid-sweep at counter=7 -> after release sweep restarts at address 0 and runs full length.
